// File: rtl/issue_pkg.sv
// issue_pkg: shared decode constants, the decode-result struct and the
// instruction decode helper used by the issue scheduler.
package issue_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] FN_JR    = 6'b001000;

   localparam logic [31:0] NOP_WORD = 32'h0000_0000;

   typedef struct packed {
      logic [4:0] src1;
      logic [4:0] src2;
      logic       use1;
      logic       use2;
      logic [4:0] dest;
      logic       writes;   // set only for a nonzero destination
      logic       is_ctrl;
   } dec_t;

   // Decode register usage and control class of one instruction word.
   function automatic dec_t decode_instr(input logic [31:0] instr);
      dec_t d;
      d.src1    = instr[25:21];
      d.src2    = instr[20:16];
      d.use1    = 1'b1;
      d.use2    = 1'b1;
      d.dest    = 5'd0;
      d.writes  = 1'b0;
      d.is_ctrl = 1'b0;
      case (instr[31:26])
         OP_RTYPE: begin
            if (instr[5:0] == FN_JR) begin
               d.use2    = 1'b0;
               d.is_ctrl = 1'b1;
            end else begin
               d.dest   = instr[15:11];
               d.writes = 1'b1;
            end
         end
         OP_LW, OP_ADDI, OP_ANDI, OP_ORI: begin
            d.use2   = 1'b0;
            d.dest   = instr[20:16];
            d.writes = 1'b1;
         end
         OP_SW: begin
            d.writes = 1'b0;
         end
         OP_BEQ, OP_BNE: begin
            d.is_ctrl = 1'b1;
         end
         OP_J: begin
            d.use1    = 1'b0;
            d.use2    = 1'b0;
            d.is_ctrl = 1'b1;
         end
         OP_JAL: begin
            d.use1    = 1'b0;
            d.use2    = 1'b0;
            d.is_ctrl = 1'b1;
            d.dest    = 5'd31;
            d.writes  = 1'b1;
         end
         default: begin
            d.writes = 1'b0;
         end
      endcase
      // gr0 is hardwired, and the all-zero word is a pure NOP.
      d.writes = d.writes && (d.dest != 5'd0) && (instr != NOP_WORD);
      return d;
   endfunction

endpackage

// File: rtl/issue_fifo.sv
// issue_fifo: 32-bit instruction buffer, FIFO_DEPTH entries (power of two).
// Ports: i_clk, i_rst_n (async active-low), i_push/i_data write side,
//        i_pop read side, o_data = current head, o_count = occupancy,
//        o_empty = no entries.
module issue_fifo #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic                        i_clk,
   input  logic                        i_rst_n,
   input  logic                        i_push,
   input  logic [31:0]                 i_data,
   input  logic                        i_pop,
   output logic [31:0]                 o_data,
   output logic [$clog2(FIFO_DEPTH):0] o_count,
   output logic                        o_empty
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   logic [31:0]   r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          w_do_push;
   logic          w_do_pop;

   assign w_do_push = i_push && (r_count != CW'(FIFO_DEPTH));
   assign w_do_pop  = i_pop && (r_count != CW'(0));
   assign o_data    = r_mem[r_rd_ptr];
   assign o_count   = r_count;
   assign o_empty   = (r_count == CW'(0));

   // Storage, pointers (wrap naturally at power-of-two depth) and occupancy.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            r_mem[i] <= 32'h0000_0000;
         end
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
            r_wr_ptr        <= r_wr_ptr + AW'(1);
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/instr_issue_scheduler.sv
// instr_issue_scheduler: buffers instruction words and issues them to the
// CPU, inserting bubbles only for RAW hazards and control-transfer shadows.
// Ports: clock, rst_n (async active-low); in_valid/in_instr/in_ready input
//        handshake; out_instr registered word to the CPU (0 when idle or
//        bubbling); out_bubble / out_issue classify out_instr;
//        issue_cnt / bubble_cnt saturating statistics.
module instr_issue_scheduler
   import issue_pkg::*;
#(
   parameter int PIPE_DEPTH = 4,
   parameter int BR_SHADOW  = 4,
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_W      = 16
) (
   input  logic             clock,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [31:0]      in_instr,
   output logic             in_ready,
   output logic [31:0]      out_instr,
   output logic             out_bubble,
   output logic             out_issue,
   output logic [CNT_W-1:0] issue_cnt,
   output logic [CNT_W-1:0] bubble_cnt
);

   localparam int FCW  = $clog2(FIFO_DEPTH) + 1;
   localparam int SH_W = (BR_SHADOW > 0) ? $clog2(BR_SHADOW + 1) : 1;
   localparam logic [SH_W-1:0] SH_LOAD = SH_W'(BR_SHADOW);

   logic [31:0]     w_head;
   logic [FCW-1:0]  w_count;
   logic            w_empty;
   logic            w_push;
   logic            w_pop;
   dec_t            w_dec;
   logic            w_hazard;
   logic            w_issue;
   logic            w_bubble;
   logic [SH_W-1:0] w_shadow_nxt;

   logic [PIPE_DEPTH-1:0] r_sb_valid;
   logic [4:0]            r_sb_dest [PIPE_DEPTH];
   logic [SH_W-1:0]       r_shadow;
   logic [31:0]           r_out_instr;
   logic                  r_out_bubble;
   logic                  r_out_issue;
   logic [CNT_W-1:0]      r_issue_cnt;
   logic [CNT_W-1:0]      r_bubble_cnt;

   // Ready comes from the registered count only, so a pop in the same cycle
   // never opens room for a push into a full buffer.
   assign in_ready = (w_count < FCW'(FIFO_DEPTH));
   assign w_push   = in_valid && in_ready;
   assign w_pop    = w_issue;

   issue_fifo #(
      .FIFO_DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .i_clk   (clock),
      .i_rst_n (rst_n),
      .i_push  (w_push),
      .i_data  (in_instr),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_count (w_count),
      .o_empty (w_empty)
   );

   assign w_dec = decode_instr(w_head);

   // RAW hazard: a used, nonzero source of the head matches any live slot.
   always_comb begin
      w_hazard = 1'b0;
      for (int i = 0; i < PIPE_DEPTH; i++) begin
         if (r_sb_valid[i]) begin
            if (w_dec.use1 && (w_dec.src1 != 5'd0) && (w_dec.src1 == r_sb_dest[i])) begin
               w_hazard = 1'b1;
            end else if (w_dec.use2 && (w_dec.src2 != 5'd0) && (w_dec.src2 == r_sb_dest[i])) begin
               w_hazard = 1'b1;
            end else begin
               w_hazard = w_hazard;
            end
         end else begin
            w_hazard = w_hazard;
         end
      end
   end

   // Per-cycle decision: shadow, then empty, then hazard, then issue.
   always_comb begin
      w_issue      = 1'b0;
      w_bubble     = 1'b0;
      w_shadow_nxt = r_shadow;
      if (r_shadow != SH_W'(0)) begin
         w_bubble     = 1'b1;
         w_shadow_nxt = r_shadow - SH_W'(1);
      end else if (w_empty) begin
         w_issue = 1'b0;
      end else if (w_hazard) begin
         w_bubble = 1'b1;
      end else begin
         w_issue = 1'b1;
         if (w_dec.is_ctrl) begin
            w_shadow_nxt = SH_LOAD;
         end else begin
            w_shadow_nxt = r_shadow;
         end
      end
   end

   // Scoreboard shift register and shadow counter.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         r_sb_valid <= '0;
         for (int i = 0; i < PIPE_DEPTH; i++) begin
            r_sb_dest[i] <= 5'd0;
         end
         r_shadow <= '0;
      end else begin
         r_sb_valid[0] <= w_issue && w_dec.writes;
         r_sb_dest[0]  <= w_dec.dest;
         for (int i = 1; i < PIPE_DEPTH; i++) begin
            r_sb_valid[i] <= r_sb_valid[i-1];
            r_sb_dest[i]  <= r_sb_dest[i-1];
         end
         r_shadow <= w_shadow_nxt;
      end
   end

   // Registered outputs and saturating statistics counters.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         r_out_instr  <= NOP_WORD;
         r_out_bubble <= 1'b0;
         r_out_issue  <= 1'b0;
         r_issue_cnt  <= '0;
         r_bubble_cnt <= '0;
      end else begin
         r_out_instr  <= w_issue ? w_head : NOP_WORD;
         r_out_bubble <= w_bubble;
         r_out_issue  <= w_issue;
         if (w_issue && (r_issue_cnt != {CNT_W{1'b1}})) begin
            r_issue_cnt <= r_issue_cnt + CNT_W'(1);
         end
         if (w_bubble && (r_bubble_cnt != {CNT_W{1'b1}})) begin
            r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
         end
      end
   end

   assign out_instr  = r_out_instr;
   assign out_bubble = r_out_bubble;
   assign out_issue  = r_out_issue;
   assign issue_cnt  = r_issue_cnt;
   assign bubble_cnt = r_bubble_cnt;

endmodule

// File: tb/tb_instr_issue_scheduler.sv
// Directed bench for instr_issue_scheduler (default parameters).
module tb_instr_issue_scheduler;

   localparam logic [31:0] LW1    = 32'h8C01_0001; // lw  gr1,1(gr0)
   localparam logic [31:0] LW2    = 32'h8C02_0002; // lw  gr2,2(gr0)
   localparam logic [31:0] SW3    = 32'hAC03_0000; // sw  gr3,0(gr0)
   localparam logic [31:0] SW1    = 32'hAC01_0000; // sw  gr1,0(gr0)
   localparam logic [31:0] ADD3   = 32'h0022_1820; // add gr3,gr1,gr2
   localparam logic [31:0] BEQ    = 32'h1000_000F; // beq gr0,gr0,0x000F
   localparam logic [31:0] JR1    = 32'h0020_0008; // jr  gr1
   localparam logic [31:0] ADD0   = 32'h0022_0020; // add gr0,gr1,gr2
   localparam logic [31:0] ADD300 = 32'h0000_1820; // add gr3,gr0,gr0
   localparam logic [31:0] O1     = 32'h3401_0001; // ori gr1,gr0,1
   localparam logic [31:0] O2     = 32'h3402_0002;
   localparam logic [31:0] O3     = 32'h3403_0003;
   localparam logic [31:0] O4     = 32'h3404_0004;

   logic        clock;
   logic        rst_n;
   logic        in_valid;
   logic [31:0] in_instr;
   logic        in_ready;
   logic [31:0] out_instr;
   logic        out_bubble;
   logic        out_issue;
   logic [15:0] issue_cnt;
   logic [15:0] bubble_cnt;

   int n_checks = 0;
   int n_errors = 0;

   instr_issue_scheduler dut (
      .clock      (clock),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_instr   (in_instr),
      .in_ready   (in_ready),
      .out_instr  (out_instr),
      .out_bubble (out_bubble),
      .out_issue  (out_issue),
      .issue_cnt  (issue_cnt),
      .bubble_cnt (bubble_cnt)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Called at a negedge: drive inputs, let one rising edge pass, check outputs.
   task automatic step(input string tag, input logic v, input logic [31:0] w,
                       input logic e_issue, input logic e_bubble, input logic [31:0] e_instr);
      in_valid = v;
      in_instr = w;
      @(negedge clock);
      chk({tag, "_issue"},  32'(out_issue),  32'(e_issue));
      chk({tag, "_bubble"}, 32'(out_bubble), 32'(e_bubble));
      chk({tag, "_instr"},  out_instr,       e_instr);
   endtask

   task automatic rst_pulse();
      in_valid = 1'b0;
      in_instr = 32'h0;
      rst_n    = 1'b0;
      #2;
      rst_n    = 1'b1;
      @(negedge clock);
   endtask

   initial begin
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_instr = 32'h0;
      #1;
      chk("rst_instr",  out_instr,          32'h0);
      chk("rst_bubble", 32'(out_bubble),    32'h0);
      chk("rst_issue",  32'(out_issue),     32'h0);
      chk("rst_icnt",   32'(issue_cnt),     32'h0);
      chk("rst_bcnt",   32'(bubble_cnt),    32'h0);
      chk("rst_ready",  32'(in_ready),      32'h1);
      #1;
      rst_n = 1'b1;
      @(negedge clock);

      // Independent stream: three back-to-back issues, no bubbles.
      step("ind0", 1'b1, LW1, 1'b0, 1'b0, 32'h0);
      step("ind1", 1'b1, LW2, 1'b1, 1'b0, LW1);
      step("ind2", 1'b1, SW3, 1'b1, 1'b0, LW2);
      step("ind3", 1'b0, 32'h0, 1'b1, 1'b0, SW3);
      step("ind4", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      chk("ind_icnt", 32'(issue_cnt),  32'd3);
      chk("ind_bcnt", 32'(bubble_cnt), 32'd0);

      // Load-use hazard: four bubbles before the add.
      rst_pulse();
      step("lu0", 1'b1, LW1,  1'b0, 1'b0, 32'h0);
      step("lu1", 1'b1, LW2,  1'b1, 1'b0, LW1);
      step("lu2", 1'b1, ADD3, 1'b1, 1'b0, LW2);
      for (int i = 0; i < 4; i++) begin
         step($sformatf("lu_bub%0d", i), 1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
      end
      step("lu_add", 1'b0, 32'h0, 1'b1, 1'b0, ADD3);
      chk("lu_bcnt", 32'(bubble_cnt), 32'd4);
      chk("lu_icnt", 32'(issue_cnt),  32'd3);

      // Control shadow after beq.
      rst_pulse();
      step("beq0", 1'b1, BEQ,  1'b0, 1'b0, 32'h0);
      step("beq1", 1'b1, ADD3, 1'b1, 1'b0, BEQ);
      for (int i = 0; i < 4; i++) begin
         step($sformatf("beq_bub%0d", i), 1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
      end
      step("beq_add", 1'b0, 32'h0, 1'b1, 1'b0, ADD3);
      chk("beq_bcnt", 32'(bubble_cnt), 32'd4);

      // Control shadow after jr.
      rst_pulse();
      step("jr0", 1'b1, JR1,  1'b0, 1'b0, 32'h0);
      step("jr1", 1'b1, ADD3, 1'b1, 1'b0, JR1);
      for (int i = 0; i < 4; i++) begin
         step($sformatf("jr_bub%0d", i), 1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
      end
      step("jr_add", 1'b0, 32'h0, 1'b1, 1'b0, ADD3);

      // gr0 destination never creates a hazard.
      rst_pulse();
      step("g0_0", 1'b1, ADD0,   1'b0, 1'b0, 32'h0);
      step("g0_1", 1'b1, ADD300, 1'b1, 1'b0, ADD0);
      step("g0_2", 1'b0, 32'h0,  1'b1, 1'b0, ADD300);
      chk("g0_bcnt", 32'(bubble_cnt), 32'd0);

      // Backpressure: head stalled behind a load-use hazard, buffer fills.
      rst_pulse();
      step("bp0", 1'b1, LW1,  1'b0, 1'b0, 32'h0);
      chk("bp0_ready", 32'(in_ready), 32'h1);
      step("bp1", 1'b1, ADD3, 1'b1, 1'b0, LW1);
      step("bp2", 1'b1, O1,   1'b0, 1'b1, 32'h0);
      step("bp3", 1'b1, O2,   1'b0, 1'b1, 32'h0);
      step("bp4", 1'b1, O3,   1'b0, 1'b1, 32'h0);
      chk("bp4_ready", 32'(in_ready), 32'h0);
      step("bp5", 1'b1, O4,   1'b0, 1'b1, 32'h0);
      chk("bp5_ready", 32'(in_ready), 32'h0);
      step("bp6", 1'b1, O4,   1'b1, 1'b0, ADD3);
      chk("bp6_ready", 32'(in_ready), 32'h1);
      step("bp7", 1'b1, O4,   1'b1, 1'b0, O1);
      step("bp8", 1'b0, 32'h0, 1'b1, 1'b0, O2);
      step("bp9", 1'b0, 32'h0, 1'b1, 1'b0, O3);
      step("bp10", 1'b0, 32'h0, 1'b1, 1'b0, O4);
      step("bp11", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      chk("bp_icnt", 32'(issue_cnt),  32'd6);
      chk("bp_bcnt", 32'(bubble_cnt), 32'd4);

      // Reset mid-stream with three words buffered.
      rst_pulse();
      step("mr0", 1'b1, LW1,  1'b0, 1'b0, 32'h0);
      step("mr1", 1'b1, ADD3, 1'b1, 1'b0, LW1);
      step("mr2", 1'b1, O1,   1'b0, 1'b1, 32'h0);
      step("mr3", 1'b1, O2,   1'b0, 1'b1, 32'h0);
      in_valid = 1'b0;
      in_instr = 32'h0;
      rst_n    = 1'b0;
      #1;
      chk("mr_rst_instr",  out_instr,       32'h0);
      chk("mr_rst_bubble", 32'(out_bubble), 32'h0);
      chk("mr_rst_issue",  32'(out_issue),  32'h0);
      chk("mr_rst_icnt",   32'(issue_cnt),  32'h0);
      chk("mr_rst_bcnt",   32'(bubble_cnt), 32'h0);
      chk("mr_rst_ready",  32'(in_ready),   32'h1);
      #1;
      rst_n = 1'b1;
      step("mr4", 1'b1, LW2,   1'b0, 1'b0, 32'h0);
      step("mr5", 1'b1, SW1,   1'b1, 1'b0, LW2);
      step("mr6", 1'b0, 32'h0, 1'b1, 1'b0, SW1);
      step("mr7", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      chk("mr_bcnt", 32'(bubble_cnt), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/instr_issue_scheduler.md
# instr_issue_scheduler

Parametrised instruction issue stage between the instruction source (bench or fetch memory) and the `CPU` pipeline's `i_datain` input. It buffers incoming instruction words in a small FIFO and tracks in-flight register writes in a scoreboard. It inserts NOP bubbles only when a RAW hazard or a control-transfer shadow requires one, replacing the fixed four-NOP padding currently written by hand after every instruction.

## Interface
- `PIPE_DEPTH`, default 4: cycles a destination register stays unreadable after issue; number of scoreboard slots, ≥1.
- `BR_SHADOW`, default 4: bubbles forced after a control instruction issues, ≥0.
- `FIFO_DEPTH`, default 4: input buffer entries, power of two, ≥2.
- `CNT_W`, default 16: width of the statistics counters.
- `clock` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: `in_instr` is valid.
- `in_instr` in 32: MIPS instruction word.
- `in_ready` out 1: FIFO can accept; a transfer occurs on a clock edge with `in_valid && in_ready`.
- `out_instr` out 32: registered instruction to the CPU; `32'h0` when not issuing.
- `out_bubble` out 1: the current `out_instr` is a hazard or shadow bubble.
- `out_issue` out 1: the current `out_instr` is a real instruction popped from the FIFO.
- `issue_cnt` out CNT_W: count of real instructions issued; saturates.
- `bubble_cnt` out CNT_W: count of hazard and shadow bubbles; saturates.

## Operation
- **Decode** uses opcode `[31:26]`, `rs=[25:21]`, `rt=[20:16]`, `rd=[15:11]`, funct `[5:0]`.
  - R-type `000000`: reads rs and rt; writes rd. Exception: funct `001000` (jr) reads rs, writes nothing, and is a control instruction.
  - `100011` (lw), `001000`, `001100`, `001101`: read rs, write rt.
  - `101011` (sw): reads rs and rt, writes nothing.
  - `000100`/`000101` (beq/bne): read rs and rt; control.
  - `000010` (j): control, no reads.
  - `000011` (jal): control, writes gr31.
  - Any other opcode: reads rs and rt, writes nothing.
  - Register 0 never creates or matches a hazard. The all-zero word writes nothing.
- **Scoreboard**: PIPE_DEPTH slots of {valid, dest[4:0]}, shifted every cycle.
  - Slot 0 receives the instruction just issued (valid only if it writes a nonzero register). Otherwise it receives invalid.
  - The oldest slot falls off.
- **Hazard**: the FIFO head's source register equals the dest of any valid slot.
- **Shadow counter** (width clog2(BR_SHADOW+1)):
  - Loaded with BR_SHADOW when a control instruction issues.
  - Decrements by one per cycle while nonzero.
- **Per-cycle decision**, evaluated in priority order:
  1. Shadow counter ≠ 0: emit bubble and decrement.
  2. FIFO empty: emit idle NOP (both flags 0, no count).
  3. Hazard: emit bubble.
  4. Otherwise: pop the head, issue it, set `out_issue`.
- **FIFO**:
  - `in_ready = (count < FIFO_DEPTH)`, derived from registered count only.
  - When full, a same-cycle pop does not enable a push.
  - Simultaneous push and pop when not full leaves count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- **Counters**: increment by 1 and hold at 2^CNT_W−1.

## Timing
- Reset values (immediate on `rst_n` low, no clock needed):
  - `out_instr`=0, `out_bubble`=0, `out_issue`=0, both counters 0.
  - FIFO empty and `in_ready`=1.
  - Scoreboard all invalid, shadow counter 0.
- Latency: a word accepted at edge k, with FIFO empty and no hazard or shadow, appears on `out_instr` after edge k+1.
- A producer issued after edge t allows a dependent consumer no earlier than after edge t+PIPE_DEPTH+1, giving exactly PIPE_DEPTH bubbles.
- A control instruction issued after edge t is followed by exactly BR_SHADOW bubbles, then the next issue.
- Reset asserted mid-stream discards FIFO contents and scoreboard state. The first word after reset release issues with no bubbles.

## Structure
- A shared package `issue_pkg` holds:
  - opcode and funct constants (`OP_RTYPE`, `OP_LW`, `OP_SW`, `OP_BEQ`, `OP_BNE`, `OP_J`, `OP_JAL`, `OP_ADDI`, `OP_ANDI`, `OP_ORI`, `FN_JR`);
  - the `NOP_WORD` constant;
  - a decode-result struct {src1, src2, use1, use2, dest, writes, is_ctrl}.
- Sub-module `issue_fifo` (parameter FIFO_DEPTH, 32-bit, with count output) is instantiated once.
- Decode and scoreboard stay in the top module.

## Test plan
- **Independent stream:** push `lw gr1,1(gr0)`, `lw gr2,2(gr0)`, `sw gr3,0(gr0)` back to back.
  - Expect three consecutive `out_issue` cycles.
  - Expect `bubble_cnt`=0.
- **Load-use hazard:** push `lw gr1`, `lw gr2`, then `add gr3,gr1,gr2` (`{000000,gr1,gr2,gr3,00000,100000}`).
  - Expect exactly 4 bubbles between `lw gr2` and `add`.
  - Expect `bubble_cnt`=4 and `issue_cnt`=3.
- **Control shadow:** push `beq gr0,gr0,0x000F` then `add`.
  - Expect 4 bubbles after the beq, then the add.
  - Repeat with `jr gr1` and expect the same 4 bubbles.
- **gr0 destination:** push `add gr0,gr1,gr2` then `add gr3,gr0,gr0`.
  - Expect no bubble between them.
- **Backpressure:** hold `in_valid`=1 with the head stalled behind a hazard.
  - Expect `in_ready`=0 after 4 accepts.
  - Expect no words lost or duplicated, in order, after the stall clears.
- **Reset mid-stream:** pulse `rst_n` low between edges while the FIFO holds 3 words.
  - Expect all outputs 0 and `in_ready`=1 immediately.
  - Expect the next pushed `lw` to issue 1 cycle after its accept edge.
